// File: rtl/char_motion_pkg.sv
// Shared definitions for the character motion controller: state encodings,
// physics defaults and the map bounds also used by the pixel generator.
package char_motion_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_CHARGE = 2'd1,
        ST_AIR    = 2'd2
    } motion_state_t;

    localparam int WALK_SPEED  = 2;
    localparam int JUMP_VX     = 3;
    localparam int GRAVITY     = 1;
    localparam int MIN_VY      = 4;
    localparam int CHARGE_STEP = 1;
    localparam int MAX_VY      = 20;

    localparam int X_MIN = 130;
    localparam int X_MAX = 548;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the three raw player buttons.
module btn_sync (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [2:0] btn_raw,
    output logic [2:0] btn_clean
);

    logic [2:0] meta;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta      <= '0;
            btn_clean <= '0;
        end else begin
            meta      <= btn_raw;
            btn_clean <= meta;
        end
    end

endmodule

// File: rtl/char_motion_ctrl.sv
// Jump-King-style character controller: walk, charge, ballistic flight with
// wall bounce and landing on the floor or platforms, stepped once per tick.
module char_motion_ctrl
    import char_motion_pkg::*;
#(
    parameter int PHY_WIDTH       = 14,
    parameter int OBSTACLE_NUM    = 7,
    parameter int BLOCK_LEN_WIDTH = 4,
    parameter int PLAT_UNIT       = 32,
    parameter int CHAR_WIDTH_X    = 42,
    parameter int X_MIN           = char_motion_pkg::X_MIN,
    parameter int X_MAX           = char_motion_pkg::X_MAX,
    parameter int Y_MAX           = 16000,
    parameter int X_INIT          = 320,
    parameter int TICK_DIV        = 1000000,
    parameter int WALK_SPEED      = char_motion_pkg::WALK_SPEED,
    parameter int JUMP_VX         = char_motion_pkg::JUMP_VX,
    parameter int GRAVITY         = char_motion_pkg::GRAVITY,
    parameter int MIN_VY          = char_motion_pkg::MIN_VY,
    parameter int CHARGE_STEP     = char_motion_pkg::CHARGE_STEP,
    parameter int MAX_VY          = char_motion_pkg::MAX_VY
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic                                  left_btn,
    input  logic                                  right_btn,
    input  logic                                  jump_btn,
    input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       plat_x,
    input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       plat_y,
    input  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] plat_len,
    output logic [PHY_WIDTH-1:0]                    char_x,
    output logic [PHY_WIDTH-1:0]                    char_y,
    output logic [PHY_WIDTH:0]                      char_vy,
    output logic [1:0]                              state,
    output logic                                    facing,
    output logic                                    jump_pulse,
    output logic                                    land_pulse
);

    localparam int SW    = PHY_WIDTH + 2;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef logic signed [SW-1:0] sval_t;

    localparam sval_t S_X_MIN    = sval_t'(X_MIN);
    localparam sval_t S_X_MAX    = sval_t'(X_MAX);
    localparam sval_t S_Y_MAX    = sval_t'(Y_MAX);
    localparam sval_t S_CW       = sval_t'(CHAR_WIDTH_X);
    localparam sval_t S_PLAT_OFS = sval_t'(X_MIN - 10);
    localparam sval_t S_UNIT     = sval_t'(PLAT_UNIT);
    localparam sval_t S_WALK     = sval_t'(WALK_SPEED);
    localparam sval_t S_JUMP_VX  = sval_t'(JUMP_VX);
    localparam sval_t S_GRAV     = sval_t'(GRAVITY);
    localparam sval_t S_MIN_VY   = sval_t'(MIN_VY);
    localparam sval_t S_STEP     = sval_t'(CHARGE_STEP);
    localparam sval_t S_MAX_VY   = sval_t'(MAX_VY);

    logic [2:0] btn_clean;
    logic       left_s, right_s, jump_s;

    btn_sync u_btn_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn_raw   ({jump_btn, right_btn, left_btn}),
        .btn_clean (btn_clean)
    );

    assign {jump_s, right_s, left_s} = btn_clean;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  tick_cnt <= '0;
        else if (tick)   tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    motion_state_t         state_q, nxt_state;
    logic [PHY_WIDTH-1:0]  x_q, y_q, charge_q, nxt_x, nxt_y, nxt_charge;
    logic signed [PHY_WIDTH:0] vy_q, vx_q, nxt_vy, nxt_vx;
    logic                  facing_q, nxt_facing, nxt_jump_pulse, nxt_land_pulse;

    sval_t x_s, y_s, vy_s, vx_s, dir, walk_x, air_x, air_vx;
    sval_t ny, best_y, vy_dec, charge_inc;
    logic  ground_sup, plat_hit;

    function automatic sval_t plat_top(input int k);
        return sval_t'(plat_y[k*PHY_WIDTH +: PHY_WIDTH]);
    endfunction

    // Platform screen span starts 10 px left of the map-relative edge plus X_MIN.
    function automatic logic overlaps(input sval_t cx, input int k);
        sval_t left, len;
        len  = sval_t'(plat_len[k*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH]);
        left = sval_t'(plat_x[k*PHY_WIDTH +: PHY_WIDTH]) + S_PLAT_OFS;
        return (len != '0) && (cx + S_CW > left) && (cx < left + len * S_UNIT);
    endfunction

    always_comb begin
        x_s  = sval_t'(x_q);
        y_s  = sval_t'(y_q);
        vy_s = sval_t'(vy_q);
        vx_s = sval_t'(vx_q);

        if (right_s && !left_s)      dir = sval_t'(1);
        else if (left_s && !right_s) dir = sval_t'(-1);
        else                         dir = '0;

        walk_x = x_s + dir * S_WALK;
        if (walk_x < S_X_MIN) walk_x = S_X_MIN;
        if (walk_x > S_X_MAX) walk_x = S_X_MAX;

        ground_sup = (y_q == '0);
        for (int k = 0; k < OBSTACLE_NUM; k++) begin
            if (overlaps(walk_x, k) && plat_top(k) == y_s) ground_sup = 1'b1;
        end

        air_x  = x_s + vx_s;
        air_vx = vx_s;
        if (air_x < S_X_MIN) begin
            air_x  = S_X_MIN;
            air_vx = -vx_s;
        end else if (air_x > S_X_MAX) begin
            air_x  = S_X_MAX;
            air_vx = -vx_s;
        end

        // Landing uses the post-bounce x; the highest crossed platform wins.
        ny       = y_s + vy_s;
        plat_hit = 1'b0;
        best_y   = '0;
        if (vy_s <= 0) begin
            for (int k = 0; k < OBSTACLE_NUM; k++) begin
                if (overlaps(air_x, k) && ny <= plat_top(k) && plat_top(k) <= y_s
                    && (!plat_hit || plat_top(k) > best_y)) begin
                    plat_hit = 1'b1;
                    best_y   = plat_top(k);
                end
            end
        end

        vy_dec = vy_s - S_GRAV;
        if (vy_dec < -S_MAX_VY) vy_dec = -S_MAX_VY;

        charge_inc = sval_t'(charge_q) + S_STEP;
        if (charge_inc > S_MAX_VY) charge_inc = S_MAX_VY;

        nxt_state      = state_q;
        nxt_x          = x_q;
        nxt_y          = y_q;
        nxt_vy         = vy_q;
        nxt_vx         = vx_q;
        nxt_charge     = charge_q;
        nxt_facing     = facing_q;
        nxt_jump_pulse = 1'b0;
        nxt_land_pulse = 1'b0;

        case (state_q)
            ST_GROUND: begin
                if (jump_s) begin
                    nxt_state  = ST_CHARGE;
                    nxt_charge = PHY_WIDTH'(S_MIN_VY);
                end else begin
                    nxt_x = PHY_WIDTH'(walk_x);
                    if (dir > 0) nxt_facing = 1'b1;
                    if (dir < 0) nxt_facing = 1'b0;
                    if (!ground_sup) begin
                        nxt_state = ST_AIR;
                        nxt_vy    = '0;
                        nxt_vx    = '0;
                    end
                end
            end
            ST_CHARGE: begin
                if (jump_s) begin
                    nxt_charge = PHY_WIDTH'(charge_inc);
                end else begin
                    nxt_vy         = (PHY_WIDTH+1)'(sval_t'(charge_q));
                    nxt_vx         = (PHY_WIDTH+1)'(dir * S_JUMP_VX);
                    nxt_state      = ST_AIR;
                    nxt_jump_pulse = 1'b1;
                end
            end
            ST_AIR: begin
                nxt_x  = PHY_WIDTH'(air_x);
                nxt_vx = (PHY_WIDTH+1)'(air_vx);
                if (plat_hit || ny <= 0) begin
                    nxt_y          = plat_hit ? PHY_WIDTH'(best_y) : '0;
                    nxt_vy         = '0;
                    nxt_vx         = '0;
                    nxt_state      = ST_GROUND;
                    nxt_land_pulse = 1'b1;
                end else if (ny > S_Y_MAX) begin
                    nxt_y  = PHY_WIDTH'(S_Y_MAX);
                    nxt_vy = '0;
                end else begin
                    nxt_y  = PHY_WIDTH'(ny);
                    nxt_vy = (PHY_WIDTH+1)'(vy_dec);
                end
            end
            default: nxt_state = ST_GROUND;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_GROUND;
            x_q        <= PHY_WIDTH'(X_INIT);
            y_q        <= '0;
            vy_q       <= '0;
            vx_q       <= '0;
            charge_q   <= PHY_WIDTH'(MIN_VY);
            facing_q   <= 1'b1;
            jump_pulse <= 1'b0;
            land_pulse <= 1'b0;
        end else begin
            jump_pulse <= tick & nxt_jump_pulse;
            land_pulse <= tick & nxt_land_pulse;
            if (tick) begin
                state_q  <= nxt_state;
                x_q      <= nxt_x;
                y_q      <= nxt_y;
                vy_q     <= nxt_vy;
                vx_q     <= nxt_vx;
                charge_q <= nxt_charge;
                facing_q <= nxt_facing;
            end
        end
    end

    assign char_x  = x_q;
    assign char_y  = y_q;
    assign char_vy = vy_q;
    assign state   = state_q;
    assign facing  = facing_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Bench for char_motion_ctrl: scenario tasks plus randomized play, each tick
// compared against an integer model of the motion rules.
module tb_char_motion_ctrl;

    localparam int PW   = 14;
    localparam int NP   = 7;
    localparam int LW   = 4;
    localparam int TDIV = 4;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic left_btn = 1'b0, right_btn = 1'b0, jump_btn = 1'b0;
    logic [NP*PW-1:0] plat_x = '0, plat_y = '0;
    logic [NP*LW-1:0] plat_len = '0;
    logic [PW-1:0]    char_x, char_y;
    logic [PW:0]      char_vy;
    logic [1:0]       state;
    logic             facing, jump_pulse, land_pulse;

    char_motion_ctrl #(.TICK_DIV(TDIV)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .left_btn   (left_btn),
        .right_btn  (right_btn),
        .jump_btn   (jump_btn),
        .plat_x     (plat_x),
        .plat_y     (plat_y),
        .plat_len   (plat_len),
        .char_x     (char_x),
        .char_y     (char_y),
        .char_vy    (char_vy),
        .state      (state),
        .facing     (facing),
        .jump_pulse (jump_pulse),
        .land_pulse (land_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // Own cycle count since reset release; every TDIV-th edge is a physics tick.
    int cyc;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    int m_x, m_y, m_vy, m_vx, m_charge, m_st;
    bit m_face, m_jp, m_lp;
    int p_x[NP], p_y[NP], p_len[NP];

    logic [47:0] dut_snap;
    assign dut_snap = {char_x, char_y, char_vy, state, facing, jump_pulse, land_pulse};

    function automatic logic [47:0] exp_snap();
        return {PW'(m_x), PW'(m_y), (PW+1)'(m_vy), 2'(m_st), m_face, m_jp, m_lp};
    endfunction

    function automatic string fmt(input logic [47:0] s);
        return $sformatf("x=%0d y=%0d vy=%0d st=%0d face=%0d jp=%0d lp=%0d",
                         s[47:34], s[33:20], $signed(s[19:5]), s[4:3], s[2], s[1], s[0]);
    endfunction

    function automatic bit m_overlap(input int x, input int k);
        int left;
        left = p_x[k] + 120;
        return p_len[k] != 0 && x + 42 > left && x < left + p_len[k] * 32;
    endfunction

    function automatic bit m_support(input int x, input int y);
        if (y == 0) return 1'b1;
        for (int k = 0; k < NP; k++)
            if (m_overlap(x, k) && p_y[k] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_x = 320; m_y = 0; m_vy = 0; m_vx = 0; m_charge = 4;
        m_st = 0; m_face = 1'b1; m_jp = 1'b0; m_lp = 1'b0;
    endtask

    task automatic model_land(input int y);
        m_y = y; m_vy = 0; m_vx = 0; m_st = 0; m_lp = 1'b1;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        int dir, nx, ny, best;
        dir = 0;
        if (r && !l) dir = 1;
        else if (l && !r) dir = -1;
        m_jp = 1'b0;
        m_lp = 1'b0;
        if (m_st == 0) begin
            if (j) begin
                m_st = 1;
                m_charge = 4;
            end else begin
                nx = m_x + 2 * dir;
                m_x = (nx < 130) ? 130 : (nx > 548) ? 548 : nx;
                if (dir != 0) m_face = (dir > 0);
                if (!m_support(m_x, m_y)) begin
                    m_st = 2; m_vy = 0; m_vx = 0;
                end
            end
        end else if (m_st == 1) begin
            if (j) m_charge = (m_charge + 1 > 20) ? 20 : m_charge + 1;
            else begin
                m_vy = m_charge; m_vx = 3 * dir; m_st = 2; m_jp = 1'b1;
            end
        end else begin
            nx = m_x + m_vx;
            if (nx < 130) begin m_x = 130; m_vx = -m_vx; end
            else if (nx > 548) begin m_x = 548; m_vx = -m_vx; end
            else m_x = nx;
            ny = m_y + m_vy;
            best = -1;
            if (m_vy <= 0)
                for (int k = 0; k < NP; k++)
                    if (m_overlap(m_x, k) && ny <= p_y[k] && p_y[k] <= m_y && p_y[k] > best)
                        best = p_y[k];
            if (best >= 0) model_land(best);
            else if (ny <= 0) model_land(0);
            else if (ny > 16000) begin m_y = 16000; m_vy = 0; end
            else begin
                m_y = ny;
                m_vy = (m_vy - 1 < -20) ? -20 : m_vy - 1;
            end
        end
    endtask

    task automatic do_tick(input bit l, input bit r, input bit j);
        left_btn = l; right_btn = r; jump_btn = j;
        do begin
            @(posedge sys_clk);
            #1;
        end while (cyc % TDIV != 0);
        model_tick(l, r, j);
    endtask

    task automatic clear_plats();
        for (int k = 0; k < NP; k++) begin
            p_x[k] = 0; p_y[k] = 0; p_len[k] = 0;
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        left_btn = 1'b0; right_btn = 1'b0; jump_btn = 1'b0;
        for (int k = 0; k < NP; k++) begin
            plat_x[k*PW +: PW]   = PW'(p_x[k]);
            plat_y[k*PW +: PW]   = PW'(p_y[k]);
            plat_len[k*LW +: LW] = LW'(p_len[k]);
        end
        model_reset();
        #12;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_plats();
        do_reset();
        total++;
        if (dut_snap !== exp_snap()) begin
            bad++;
            $display("[TB] FAIL reset: got %s, expected %s", fmt(dut_snap), fmt(exp_snap()));
        end
        total++;
        if (char_x !== 14'd320) begin
            bad++;
            $display("[TB] FAIL reset x: got %0d, expected 320", char_x);
        end
    endtask

    task automatic test_walk();
        clear_plats();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i < 10)      do_tick(1'b0, 1'b1, 1'b0);
            else if (i < 13) do_tick(1'b1, 1'b1, 1'b0);
            else             do_tick(1'b1, 1'b0, 1'b0);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL walk tick %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
            if (i == 9 || i == 12) begin
                total++;
                if (char_x !== 14'd340 || facing !== 1'b1 || state !== 2'd0) begin
                    bad++;
                    $display("[TB] FAIL walk x340 tick %0d: got x=%0d face=%0d st=%0d, expected x=340 face=1 st=0",
                             i, char_x, facing, state);
                end
            end
        end
    endtask

    task automatic test_vertical_jump();
        int peak, landed_at;
        clear_plats();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_tick(1'b0, 1'b0, i < 7);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL charge tick %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
        end
        total++;
        if (char_vy !== 15'd10 || jump_pulse !== 1'b1) begin
            bad++;
            $display("[TB] FAIL takeoff: got vy=%0d jp=%0d, expected vy=10 jp=1", $signed(char_vy), jump_pulse);
        end
        @(posedge sys_clk);
        #1;
        total++;
        if (jump_pulse !== 1'b0) begin
            bad++;
            $display("[TB] FAIL jump pulse width: got %0d one cycle later, expected 0", jump_pulse);
        end
        peak = 0;
        landed_at = 0;
        for (int i = 1; i <= 40; i++) begin
            do_tick(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL air tick %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
            if (int'(char_y) > peak) peak = int'(char_y);
            if (land_pulse === 1'b1) begin
                landed_at = i;
                break;
            end
        end
        total++;
        if (peak != 55 || landed_at != 21 || char_x !== 14'd320) begin
            bad++;
            $display("[TB] FAIL jump profile: got peak=%0d land_tick=%0d x=%0d, expected 55 21 320",
                     peak, landed_at, char_x);
        end
    endtask

    task automatic test_saturation();
        bit landed;
        clear_plats();
        do_reset();
        for (int i = 0; i < 42; i++) begin
            do_tick(1'b0, 1'b0, i < 41);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL saturate tick %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
        end
        total++;
        if (char_vy !== 15'd20) begin
            bad++;
            $display("[TB] FAIL saturate vy: got %0d, expected 20", $signed(char_vy));
        end
        landed = 1'b0;
        for (int i = 0; i < 80 && !landed; i++) begin
            do_tick(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL saturate air %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
            landed = (land_pulse === 1'b1);
        end
        total++;
        if (!landed) begin
            bad++;
            $display("[TB] FAIL saturate land timeout: got st=%0d, expected landing", state);
        end
    endtask

    task automatic test_wall_bounce();
        int exp_x[4];
        bit landed;
        exp_x = '{543, 546, 548, 545};
        clear_plats();
        do_reset();
        for (int i = 0; i < 110; i++) do_tick(1'b0, 1'b1, 1'b0);
        total++;
        if (char_x !== 14'd540 || dut_snap !== exp_snap()) begin
            bad++;
            $display("[TB] FAIL walk to wall: got %s, expected x=540 %s", fmt(dut_snap), fmt(exp_snap()));
        end
        for (int i = 0; i < 7; i++) do_tick(1'b0, 1'b0, 1'b1);
        do_tick(1'b0, 1'b1, 1'b0);
        landed = 1'b0;
        for (int i = 0; i < 40 && !landed; i++) begin
            do_tick(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_snap !== exp_snap() || (i < 4 && int'(char_x) != exp_x[i])) begin
                bad++;
                $display("[TB] FAIL bounce tick %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
            landed = (land_pulse === 1'b1);
        end
        total++;
        if (!landed || char_x >= 14'd540) begin
            bad++;
            $display("[TB] FAIL bounce end: got x=%0d landed=%0d, expected x<540 landed=1", char_x, landed);
        end
    endtask

    task automatic test_platform();
        bit done;
        clear_plats();
        p_x[0] = 200; p_y[0] = 30; p_len[0] = 4;
        do_reset();
        for (int i = 0; i < 7; i++) do_tick(1'b0, 1'b0, 1'b1);
        do_tick(1'b0, 1'b0, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            do_tick(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL plat air %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
            done = (land_pulse === 1'b1);
        end
        total++;
        if (char_y !== 14'd30 || state !== 2'd0) begin
            bad++;
            $display("[TB] FAIL plat land: got y=%0d st=%0d, expected y=30 st=0", char_y, state);
        end
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            do_tick(1'b0, 1'b1, 1'b0);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL plat walk %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
            done = (state === 2'd2);
        end
        total++;
        if (!done || char_vy !== 15'd0 || char_y !== 14'd30) begin
            bad++;
            $display("[TB] FAIL walk off edge: got st=%0d vy=%0d y=%0d, expected st=2 vy=0 y=30",
                     state, $signed(char_vy), char_y);
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            do_tick(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL plat fall %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
            done = (land_pulse === 1'b1);
        end
        total++;
        if (!done || char_y !== 14'd0) begin
            bad++;
            $display("[TB] FAIL fall to floor: got y=%0d landed=%0d, expected y=0 landed=1", char_y, done);
        end
    endtask

    task automatic test_random();
        bit l, r, j;
        for (int k = 0; k < NP; k++) begin
            p_len[k] = $urandom_range(0, 4);
            p_x[k]   = $urandom_range(0, 420);
            p_y[k]   = $urandom_range(1, 8) * 8;
        end
        do_reset();
        for (int i = 0; i < 300; i++) begin
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 3) == 0);
            do_tick(l, r, j);
            total++;
            if (dut_snap !== exp_snap()) begin
                bad++;
                $display("[TB] FAIL random tick %0d: got %s, expected %s", i, fmt(dut_snap), fmt(exp_snap()));
            end
        end
    endtask

    task automatic test_reset_midair();
        clear_plats();
        do_reset();
        for (int i = 0; i < 7; i++) do_tick(1'b0, 1'b0, 1'b1);
        do_tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && char_y !== 14'd40; i++) do_tick(1'b0, 1'b0, 1'b0);
        total++;
        if (char_y !== 14'd40 || state !== 2'd2) begin
            bad++;
            $display("[TB] FAIL reach y40: got y=%0d st=%0d, expected y=40 st=2", char_y, state);
        end
        #3;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_snap !== exp_snap()) begin
            bad++;
            $display("[TB] FAIL async reset: got %s, expected %s", fmt(dut_snap), fmt(exp_snap()));
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_vertical_jump();
        test_saturation();
        test_wall_bounce();
        test_platform();
        test_random();
        test_reset_midair();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("[TB] FAIL watchdog: got no completion by 2 ms, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
